// File: rtl/counter_rr_sched.sv
// counter_rr_sched: round-robin scheduler that shares one increment path among
// NUM_REQ requesters. Each requester owns a CNT_WIDTH counter. At most one
// requester is granted at a time, and only the granted counter advances. A grant
// lasts at most BURST_LEN increments before arbitration runs again.
//
// Optional build macro COUNTER_SCHED_SAT_EN: when it is defined, the counters
// saturate at all-ones and wrap_o stays 0. When it is undefined, the counters
// wrap modulo 2^CNT_WIDTH and raise a one-cycle wrap pulse.
module counter_rr_sched #(
    parameter int NUM_REQ   = 4,
    parameter int CNT_WIDTH = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           enable_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0]             clr_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] gnt_id_o,
    output logic                           busy_o,
    output logic [NUM_REQ*CNT_WIDTH-1:0]   counts_o,
    output logic [NUM_REQ-1:0]             wrap_o
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW  = $clog2(BURST_LEN + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IDW-1:0]     cur_q;
    logic [IDW-1:0]     ptr_q;
    logic [BW-1:0]      burst_q;

    logic [IDW-1:0]     cur_inc_d;
    logic [IDW-1:0]     arb_base_d;
    logic [IDW:0]       pick_d;
    logic               pick_found_d;
    logic [IDW-1:0]     pick_idx_d;
    logic               cur_req_d;
    logic               inc_fire_d;
    logic               burst_done_d;

    // Return the first asserted request at or after base, wrapping past the top
    // index. The MSB of the result flags whether any request was found. The scan
    // runs from the farthest offset back toward base, so the nearest hit is the
    // last one written and therefore wins.
    function automatic logic [IDW:0] rr_pick(input logic [IDW-1:0]     base,
                                             input logic [NUM_REQ-1:0] r);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(base) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (r[IDW'(idx)]) begin
                res = {1'b1, IDW'(idx)};
            end
        end
        return res;
    endfunction

    // Convert a requester index into a one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDW-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    // Compute the arbitration inputs. While BUSY, the next grant is searched
    // starting one past the current owner; while IDLE, it starts at the pointer.
    always_comb begin
        cur_inc_d    = (cur_q == IDW'(NUM_REQ - 1)) ? '0 : cur_q + IDW'(1);
        arb_base_d   = (state_q == S_BUSY) ? cur_inc_d : ptr_q;
        pick_d       = rr_pick(arb_base_d, req_i);
        pick_found_d = pick_d[IDW];
        pick_idx_d   = pick_d[IDW-1:0];
        cur_req_d    = req_i[cur_q];
        inc_fire_d   = enable_i && (state_q == S_BUSY) && cur_req_d;
        burst_done_d = inc_fire_d && (burst_q == BW'(BURST_LEN - 1));
    end

    // Grant FSM. It holds the owner, the grant vector, the rotation pointer and
    // the burst count. A grant ends when the owner drops its request or when its
    // burst is used up. In both cases the next owner is chosen on the same edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            cur_q   <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
        end else if (enable_i) begin
            case (state_q)
                S_IDLE: begin
                    if (pick_found_d) begin
                        state_q <= S_BUSY;
                        cur_q   <= pick_idx_d;
                        gnt_q   <= to_onehot(pick_idx_d);
                        burst_q <= '0;
                    end
                end
                S_BUSY: begin
                    if (cur_req_d && !burst_done_d) begin
                        burst_q <= burst_q + BW'(1);
                    end else begin
                        ptr_q   <= cur_inc_d;
                        burst_q <= '0;
                        if (pick_found_d) begin
                            cur_q <= pick_idx_d;
                            gnt_q <= to_onehot(pick_idx_d);
                        end else begin
                            state_q <= S_IDLE;
                            gnt_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt_o    = gnt_q;
    assign gnt_id_o = cur_q;
    assign busy_o   = (state_q == S_BUSY);

    // Counter bank: one register and one wrap flag per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_q;
            logic                 wrap_q;
            logic                 inc_here;

            assign inc_here = inc_fire_d && (cur_q == IDW'(gi));

            // A clear beats a same-edge increment. The clear acts even while the
            // scheduler is disabled. The wrap flag lasts exactly one cycle.
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    cnt_q  <= '0;
                    wrap_q <= 1'b0;
                end else begin
                    wrap_q <= 1'b0;
                    if (clr_i[gi]) begin
                        cnt_q <= '0;
                    end else if (inc_here) begin
`ifdef COUNTER_SCHED_SAT_EN
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                        end
`else
                        cnt_q  <= cnt_q + CNT_WIDTH'(1);
                        wrap_q <= (cnt_q == '1);
`endif
                    end
                end
            end

            assign counts_o[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
            assign wrap_o[gi]                          = wrap_q;
        end
    endgenerate

    // The grant vector must never have more than one bit set.
    gnt_onehot_a: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(gnt_q));

endmodule

// File: tb/tb_counter_rr_sched.sv
// Testbench for counter_rr_sched. A stimulus process drives directed scenarios
// and then a random phase. After each clock edge it steps a behavioural model and
// queues the expected outputs. A separate monitor pops those expectations on the
// falling edge and compares them with the DUT outputs.
module tb_counter_rr_sched;

    localparam int N    = 4;
    localparam int W    = 4;
    localparam int BL   = 4;
    localparam int IDW  = 2;
    localparam int CW   = N * W;
    localparam int MAXV = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           enable = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   clr = '0;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic [CW-1:0]  counts;
    logic [N-1:0]   wrap;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    counter_rr_sched #(.NUM_REQ(N), .CNT_WIDTH(W), .BURST_LEN(BL)) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .enable_i (enable),
        .req_i    (req),
        .clr_i    (clr),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .busy_o   (busy),
        .counts_o (counts),
        .wrap_o   (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   gnt;
        logic           busy;
        logic [IDW-1:0] id;
        logic [CW-1:0]  counts;
        logic [N-1:0]   wrap;
    } exp_t;

    exp_t sb[$];

    // Reference model state. m_own is -1 when nobody holds a grant.
    int           m_own;
    int           m_ptr;
    int           m_burst;
    int           m_cnt[N];
    logic [N-1:0] m_wrap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int from, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int cand;
            cand = (from + k) % N;
            if (((r >> cand) & N'(1)) != '0) return cand;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_own   = -1;
        m_ptr   = 0;
        m_burst = 0;
        m_wrap  = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step(input logic en, input logic [N-1:0] r, input logic [N-1:0] c);
        exp_t e;
        int   g;
        m_wrap = '0;
        if (en) begin
            if (m_own < 0) begin
                m_own   = pick(m_ptr, r);
                m_burst = 0;
            end else if (((r >> m_own) & N'(1)) != '0) begin
                g = m_own;
                if (m_cnt[g] == MAXV) begin
`ifndef COUNTER_SCHED_SAT_EN
                    m_cnt[g] = 0;
                    m_wrap   = m_wrap | (N'(1) << g);
`endif
                end else begin
                    m_cnt[g] = m_cnt[g] + 1;
                end
                m_burst = m_burst + 1;
                if (m_burst == BL) begin
                    m_ptr   = (g + 1) % N;
                    m_own   = pick(m_ptr, r);
                    m_burst = 0;
                end
            end else begin
                m_ptr   = (m_own + 1) % N;
                m_own   = pick(m_ptr, r);
                m_burst = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (((c >> i) & N'(1)) != '0) begin
                m_cnt[i] = 0;
                m_wrap   = m_wrap & ~(N'(1) << i);
            end
        end
        e.gnt    = (m_own >= 0) ? (N'(1) << m_own) : '0;
        e.busy   = (m_own >= 0);
        e.id     = (m_own >= 0) ? IDW'(m_own) : '0;
        e.wrap   = m_wrap;
        e.counts = '0;
        for (int i = 0; i < N; i++) e.counts = e.counts | (CW'(m_cnt[i]) << (i * W));
        sb.push_back(e);
    endtask

    // Apply one set of inputs across a rising edge, then record the expectation.
    task automatic cycle(input logic en, input logic [N-1:0] r, input logic [N-1:0] c);
        enable = en;
        req    = r;
        clr    = c;
        @(posedge clk);
        #1;
        model_step(en, r, c);
    endtask

    // Assert reset between clock edges and check that it acts at once.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset  = 1'b1;
        enable = 1'b0;
        req    = '0;
        clr    = '0;
        model_reset();
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_counts", 64'(counts), 64'd0);
        chk("rst_wrap", 64'(wrap), 64'd0);
        chk("rst_gnt_id", 64'(gnt_id), 64'd0);
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Monitor: on every falling edge, compare the DUT outputs with the oldest
    // queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_txn++;
                $display("txn %0d: req=%b en=%b clr=%b gnt=%b busy=%b id=%0d counts=%h wrap=%b",
                         n_txn, req, enable, clr, gnt, busy, gnt_id, counts, wrap);
                chk("gnt", 64'(gnt), 64'(e.gnt));
                chk("busy", 64'(busy), 64'(e.busy));
                chk("counts", 64'(counts), 64'(e.counts));
                chk("wrap", 64'(wrap), 64'(e.wrap));
                if (e.busy) chk("gnt_id", 64'(gnt_id), 64'(e.id));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] r_hold;
        logic [N-1:0] r_rand;
        logic [N-1:0] c_rand;
        logic         e_rand;

        model_reset();

        // All four requesters active from reset: they take turns of four increments each.
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1'b1, 4'b1111, 4'b0000);
        chk("t3_counts", 64'(counts), 64'h4444);
        chk("t3_gnt", 64'(gnt), 64'b0001);

        // A lone requester is re-granted with no gap after each burst.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 4'b0010, 4'b0000);
        chk("t2_counts", 64'(counts), 64'h0090);
        chk("t2_gnt", 64'(gnt), 64'b0010);

        // Reset arrives in the middle of a burst with cnt1 at 5.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 4'b0010, 4'b0000);
        chk("t1_counts_pre", 64'(counts), 64'h0050);
        do_reset();

        // Counter 2 reaches all-ones and then takes one more increment.
        for (int i = 0; i < 17; i++) cycle(1'b1, 4'b0100, 4'b0000);
`ifdef COUNTER_SCHED_SAT_EN
        chk("t4_counts", 64'(counts), 64'h0F00);
        chk("t4_wrap", 64'(wrap), 64'b0000);
`else
        chk("t4_counts", 64'(counts), 64'h0000);
        chk("t4_wrap", 64'(wrap), 64'b0100);
`endif
        cycle(1'b1, 4'b0000, 4'b0000);
        chk("t4_wrap_end", 64'(wrap), 64'b0000);

        // A clear on the same edge as an increment wins.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'b0001, 4'b0000);
        cycle(1'b1, 4'b0001, 4'b0001);
        chk("t5_counts", 64'(counts), 64'h0000);
        chk("t5_gnt", 64'(gnt), 64'b0001);

        // Holding enable low pauses the scheduler in the middle of a burst.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0011, 4'b0000);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0011, 4'b0000);
        chk("t6_frozen", 64'(counts), 64'h0002);
        cycle(1'b1, 4'b0011, 4'b0000);
        cycle(1'b1, 4'b0011, 4'b0000);
        chk("t6_counts", 64'(counts), 64'h0004);
        chk("t6_gnt", 64'(gnt), 64'b0010);

        // Random phase: requests are sticky, enable drops now and then, clears are rare.
        do_reset();
        r_hold = 4'b0101;
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            r_rand = N'($urandom);
            if ($urandom_range(0, 9) < 3) r_hold = r_rand;
            e_rand = ($urandom_range(0, 9) != 0);
            c_rand = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
            cycle(e_rand, r_hold, c_rand);
        end

        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
